// File: rtl/counter_scan_pkg.sv
// Shared constants for the counter/scan display: digit width, seven-segment
// patterns ({g,f,e,d,c,b,a}, active-high) and the divide-ratio helper.
package counter_scan_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Clock cycles per event at the requested rate.
  function automatic int unsigned div_ratio(input int unsigned clk_hz,
                                            input int unsigned rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder with a blank override.
module seg7_decode
  import counter_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] value_i,
  input  logic               blank_i,
  output logic [SEG_W-1:0]   seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    if (!blank_i) begin
      case (value_i)
        4'h0: seg_c_o = SEG_0;
        4'h1: seg_c_o = SEG_1;
        4'h2: seg_c_o = SEG_2;
        4'h3: seg_c_o = SEG_3;
        4'h4: seg_c_o = SEG_4;
        4'h5: seg_c_o = SEG_5;
        4'h6: seg_c_o = SEG_6;
        4'h7: seg_c_o = SEG_7;
        4'h8: seg_c_o = SEG_8;
        4'h9: seg_c_o = SEG_9;
        4'hA: seg_c_o = SEG_A;
        4'hB: seg_c_o = SEG_B;
        4'hC: seg_c_o = SEG_C;
        4'hD: seg_c_o = SEG_D;
        4'hE: seg_c_o = SEG_E;
        4'hF: seg_c_o = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/counter_scan_display.sv
// Tick prescaler, DIGITS-wide cascaded 163-style counter and multiplexed
// seven-segment scanner with optional leading-zero blanking.
module counter_scan_display
  import counter_scan_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned COUNT_HZ = 1,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned MODULUS  = 10,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_n,
  input  logic                       load_n,
  input  logic                       enp,
  input  logic                       ent,
  input  logic                       up,
  input  logic [DIGIT_W*DIGITS-1:0]  din,
  output logic [DIGIT_W*DIGITS-1:0]  count,
  output logic                       rco,
  output logic                       tick,
  output logic [SEG_W-1:0]           seg,
  output logic [DIGITS-1:0]          sel
);

  localparam int unsigned CNT_DIV  = div_ratio(CLK_HZ, COUNT_HZ);
  localparam int unsigned SCAN_DIV = div_ratio(CLK_HZ, SCAN_HZ);
  localparam int unsigned CNT_W    = $clog2(CNT_DIV);
  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned COUNT_W  = DIGIT_W * DIGITS;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CNT_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DIG_MAX   = DIGIT_W'(MODULUS - 1);

  logic [CNT_W-1:0]   cnt_pre_q, cnt_pre_d;
  logic               tick_q, tick_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [SCAN_W-1:0]  scan_pre_q, scan_pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [DIGITS-1:0]  sel_q, sel_d;

  logic               all_max, all_zero;
  logic [DIGITS-1:0]  blank_vec;
  logic [DIGIT_W-1:0] cur_digit;
  logic               cur_blank;

  // Count prescaler; tick is high while the prescaler sits at its last value.
  always_comb begin
    cnt_pre_d = cnt_pre_q + CNT_W'(1);
    if (cnt_pre_q == CNT_LAST) begin
      cnt_pre_d = '0;
    end
    tick_d = (cnt_pre_d == CNT_LAST);
  end

  // Counter next state: clear > load (clamped) > count > hold, on tick edges only.
  always_comb begin : count_next
    logic               carry;
    logic [DIGIT_W-1:0] dig;
    count_d = count_q;
    carry   = 1'b1;
    dig     = '0;
    if (tick_q) begin
      if (!clr_n) begin
        count_d = '0;
      end else if (!load_n) begin
        for (int k = 0; k < int'(DIGITS); k++) begin
          dig = din[k*DIGIT_W +: DIGIT_W];
          count_d[k*DIGIT_W +: DIGIT_W] = (32'(dig) >= MODULUS) ? DIG_MAX : dig;
        end
      end else if (enp && ent) begin
        for (int k = 0; k < int'(DIGITS); k++) begin
          dig = count_q[k*DIGIT_W +: DIGIT_W];
          if (carry) begin
            if (up) begin
              count_d[k*DIGIT_W +: DIGIT_W] = (dig == DIG_MAX) ? '0 : dig + DIGIT_W'(1);
            end else begin
              count_d[k*DIGIT_W +: DIGIT_W] = (dig == '0) ? DIG_MAX : dig - DIGIT_W'(1);
            end
          end
          carry = carry & (up ? (dig == DIG_MAX) : (dig == '0));
        end
      end
    end
  end

  // Terminal-count detection for rco.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      all_max  = all_max  & (count_q[k*DIGIT_W +: DIGIT_W] == DIG_MAX);
      all_zero = all_zero & (count_q[k*DIGIT_W +: DIGIT_W] == '0);
    end
  end

  assign rco = ent & (up ? all_max : all_zero);

  // Scan prescaler and digit index.
  always_comb begin
    scan_pre_d = scan_pre_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_pre_q == SCAN_LAST) begin
      scan_pre_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is blanked when it and every digit above it are zero (never digit 0).
  always_comb begin : blank_scan
    logic zero_above;
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above   = zero_above & (count_q[i*DIGIT_W +: DIGIT_W] == '0);
      blank_vec[i] = (BLANK_LZ != 0) && (i != 0) && zero_above;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_digit = count_q[i*DIGIT_W +: DIGIT_W];
        cur_blank = blank_vec[i];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .value_i (cur_digit),
    .blank_i (cur_blank),
    .seg_c_o (seg_d)
  );

  assign sel_d = ~(DIGITS'(1) << idx_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_pre_q  <= '0;
      tick_q     <= 1'b0;
      count_q    <= '0;
      scan_pre_q <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_0;
      sel_q      <= ~DIGITS'(1);
    end else begin
      cnt_pre_q  <= cnt_pre_d;
      tick_q     <= tick_d;
      count_q    <= count_d;
      scan_pre_q <= scan_pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign seg   = seg_q;
  assign sel   = sel_q;

endmodule

// File: doc/counter_scan_display.md
Name: counter_scan_display

Overview:
- Parametrised successor to the single-digit 163-style counter/display path.
- Integrates a tick prescaler, a DIGITS-wide cascaded synchronous counter (load, clear, enables, up/down), and a time-multiplexed seven-segment scanner with optional leading-zero blanking.
- Sits at board top level, driven from the 50 MHz system clock, replacing the separate divider plus counter pair.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- COUNT_HZ, 1, count tick rate; divider CNT_DIV = CLK_HZ/COUNT_HZ, must be >= 2.
- SCAN_HZ, 1000, per-digit scan rate; SCAN_DIV = CLK_HZ/SCAN_HZ, must be >= 2.
- DIGITS, 4, number of digits, 1..8.
- MODULUS, 10, per-digit modulus, 2..16 (10 = BCD, 16 = hex).
- BLANK_LZ, 0, 1 = blank leading zero digits.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous, active-low reset.
- clr_n, in, 1: synchronous clear, active-low.
- load_n, in, 1: synchronous parallel load, active-low.
- enp, in, 1: count enable P.
- ent, in, 1: count enable T, also gates rco.
- up, in, 1: 1 = count up, 0 = count down.
- din, in, 4*DIGITS: load value, digit 0 in bits [3:0].
- count, out, 4*DIGITS: current count, digit 0 in bits [3:0].
- rco, out, 1: ripple carry/borrow out.
- tick, out, 1: one-clk pulse per count tick.
- seg, out, 7: segments {g,f,e,d,c,b,a}, active-high.
- sel, out, DIGITS: digit select, one-hot active-low.

Behaviour:
- Reset is sampled only on a clk edge with rst=0. After that edge:
  - count=0, prescalers=0, tick=0, scan index=0.
  - sel = all ones except bit0 = 0.
  - seg = 7'b0111111 (digit "0").
- Count prescaler:
  - Counts 0..CNT_DIV-1 and wraps.
  - tick=1 for exactly the one clk cycle in which the prescaler equals CNT_DIV-1.
- Counter updates only on clk edges where tick=1. Priority on such an edge, highest first:
  - clr_n=0: count <= 0.
  - Else load_n=0: count <= din, with any digit >= MODULUS clamped to MODULUS-1.
  - Else enp & ent & up: increment digit 0 mod MODULUS; digit k increments when all lower digits were MODULUS-1.
  - Else enp & ent & !up: decrement digit 0; a digit at 0 becomes MODULUS-1; digit k decrements when all lower digits were 0.
  - Else: hold.
- clr_n, load_n and the enables are ignored on non-tick edges, matching the 163 on a slow clock.
- Wrap-around:
  - Up from all MODULUS-1 gives all 0.
  - Down from all 0 gives all MODULUS-1.
- rco is combinational:
  - up=1: rco = ent & (all digits == MODULUS-1).
  - up=0: rco = ent & (all digits == 0).
  - rco is independent of enp and tick.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the scan index advances (DIGITS-1 wraps to 0).
- seg and sel are registered from the new index and the current count, so they update 1 clk after the index changes.
- sel has bit[index] low and all other bits high.
- seg decode, hex patterns (a = bit0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blanking when BLANK_LZ=1:
  - Digit i (i > 0) shows seg=0 if it and all higher digits are 0.
  - Digit 0 is never blanked.
- Reset mid-count or mid-scan restores all reset values on that edge. Scanning and counting restart from 0.
- Reset has priority over all other inputs.

Decomposition:
- Package counter_scan_pkg holds:
  - Seven-segment pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Function for the divide ratio.
  - Digit-width constant (4).
- One sub-module: seg7_decode (4-bit value plus blank flag in, 7-bit pattern out, combinational).
- Prescalers and the counter stay inline.

Test Plan:
All scenarios use CLK_HZ=100, COUNT_HZ=10, SCAN_HZ=50, DIGITS=4, MODULUS=10 unless stated.
1. Reset, then hold rst=1 for 25 clk -> tick pulses at clk 10 and 20 only. count=0000. sel cycles 1110, 1101, 1011, 0111 every 2 clk.
2. enp=ent=up=1 from count 0998, 2 ticks -> 0999 then 1000. rco=1 only while count=9999 with ent=1.
3. up=0 from 0000, 1 tick -> 9999. rco=1 at 0000 with ent=1; rco=0 when ent=0.
4. load_n=0 with din=16'h12F4 on a tick -> count=12 9 4 (F clamped to 9). A load asserted between ticks has no effect.
5. clr_n=0 and load_n=0 together on a tick -> count=0000 (clear wins). rst=0 mid-scan -> sel=1110 and seg=3F on the next edge.
6. BLANK_LZ=1, MODULUS=16, count=0x0070 -> digits 3 and 2 show seg=00. Digit 1 shows 07, digit 0 shows 3F.
